// File: rtl/ex_mul_pkg.sv
// Shared types for the EX-stage iterative multiplier: operation encoding,
// sequencer states and the per-operation operand signedness lookup.
package ex_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // Returns {opa_signed, opb_signed}; MUL only needs the low word, so unsigned is exact.
  function automatic logic [1:0] op_signedness(input mul_op_t op);
    logic [1:0] sgn;
    case (op)
      OP_MULH:   sgn = 2'b11;
      OP_MULHSU: sgn = 2'b10;
      OP_MUL:    sgn = 2'b00;
      OP_MULHU:  sgn = 2'b00;
      default:   sgn = 2'b00;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/ex_mul_seq_mul_step.sv
// One shift-add iteration: folds BPC multiplier bits into the 2*XLEN accumulator.
module mul_step #(
  parameter int W   = 64,
  parameter int BPC = 1
) (
  input  logic [W-1:0]   acc_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [BPC-1:0] bits_i,
  output logic [W-1:0]   acc_o
);

  // Partial products for each retired multiplier bit, full width, no truncation.
  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BPC; i++) begin
      if (bits_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end else begin
        acc_o = acc_o;
      end
    end
  end

endmodule

// File: rtl/ex_mul_seq.sv
// Iterative RV32M multiply sequencer that stalls EX until the product is ready.
// Optional result reuse for repeated operands is enabled by EX_MUL_SEQ_REUSE_EN.
module ex_mul_seq
  import ex_mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_opa,
  input  logic [XLEN-1:0] req_opb,
  input  logic [1:0]      req_op,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            ex_stall
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam int P     = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mul_state_t       state_q;
  mul_op_t          op_q;
  logic             neg_q;
  logic [CNT_W-1:0] count_q;
  logic [P-1:0]     mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [P-1:0]     acc_q;
  logic [XLEN-1:0]  resp_result_q;

  mul_op_t          req_op_s;
  logic [1:0]       sgn_s;
  logic             opa_neg_s;
  logic             opb_neg_s;
  logic [XLEN-1:0]  opa_mag_s;
  logic [XLEN-1:0]  opb_mag_s;
  logic             accept_s;
  logic             hit_s;
  logic [XLEN-1:0]  hit_result_s;
  logic [P-1:0]     acc_d;
  logic [P-1:0]     final_d;

  function automatic logic [XLEN-1:0] sel_half(input logic [P-1:0] p, input mul_op_t op);
    if (op == OP_MUL) begin
      return p[XLEN-1:0];
    end else begin
      return p[P-1:XLEN];
    end
  endfunction

  assign req_op_s  = mul_op_t'(req_op);
  assign sgn_s     = op_signedness(req_op_s);
  assign opa_neg_s = sgn_s[1] & req_opa[XLEN-1];
  assign opb_neg_s = sgn_s[0] & req_opb[XLEN-1];
  assign opa_mag_s = opa_neg_s ? -req_opa : req_opa;
  assign opb_mag_s = opb_neg_s ? -req_opb : req_opb;

  assign req_ready   = !flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & resp_ready));
  assign accept_s    = req_valid & req_ready;
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_result = resp_result_q;
  assign ex_stall    = (req_valid & !req_ready) | (state_q == ST_BUSY) |
                       ((state_q == ST_DONE) & !resp_ready);

  mul_step #(.W(P), .BPC(BITS_PER_CYCLE)) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .bits_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (acc_d)
  );

  assign final_d = neg_q ? -acc_d : acc_d;

`ifdef EX_MUL_SEQ_REUSE_EN
  logic [XLEN-1:0] last_opa_q;
  logic [XLEN-1:0] last_opb_q;
  logic [1:0]      last_sgn_q;
  logic [P-1:0]    last_prod_q;
  logic            last_valid_q;

  // A MUL only consumes the low word, which is identical for every signedness class.
  assign hit_s = last_valid_q & (req_opa == last_opa_q) & (req_opb == last_opb_q) &
                 ((req_op_s == OP_MUL) | (sgn_s == last_sgn_q));
  assign hit_result_s = sel_half(last_prod_q, req_op_s);
`else
  assign hit_s        = 1'b0;
  assign hit_result_s = '0;
`endif

  // Sequencer state, operand/accumulator datapath and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_MUL;
      neg_q         <= 1'b0;
      count_q       <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      resp_result_q <= '0;
`ifdef EX_MUL_SEQ_REUSE_EN
      last_opa_q    <= '0;
      last_opb_q    <= '0;
      last_sgn_q    <= 2'b00;
      last_prod_q   <= '0;
      last_valid_q  <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= ST_IDLE;
`ifdef EX_MUL_SEQ_REUSE_EN
      last_valid_q <= 1'b0;
`endif
    end else if (accept_s) begin
      op_q  <= req_op_s;
      neg_q <= opa_neg_s ^ opb_neg_s;
      if (hit_s) begin
        state_q       <= ST_DONE;
        resp_result_q <= hit_result_s;
      end else begin
        state_q  <= ST_BUSY;
        mcand_q  <= {{XLEN{1'b0}}, opa_mag_s};
        mplier_q <= opb_mag_s;
        acc_q    <= '0;
        count_q  <= '0;
`ifdef EX_MUL_SEQ_REUSE_EN
        last_opa_q   <= req_opa;
        last_opb_q   <= req_opb;
        last_sgn_q   <= sgn_s;
        last_valid_q <= 1'b0;
`endif
      end
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          count_q  <= count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            state_q       <= ST_DONE;
            resp_result_q <= sel_half(final_d, op_q);
`ifdef EX_MUL_SEQ_REUSE_EN
            last_prod_q  <= final_d;
            last_valid_q <= 1'b1;
`endif
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_seq.sv
// Directed self-checking bench for ex_mul_seq with hand-computed products;
// the reuse scenario runs only when EX_MUL_SEQ_REUSE_EN is defined.
module tb_ex_mul_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic [1:0]  req_op;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        ex_stall;

  int n_checks = 0;
  int n_errors = 0;

  ex_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .req_op     (req_op),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .ex_stall   (ex_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_opa   = a;
    req_opb   = b;
    req_valid = 1'b1;
    #1;
    check("issue_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until resp_valid, then checks the result.
  task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int lat = 0;
    bit stall_ok = 1'b1;
    while (!resp_valid && lat < 100) begin
      if (!ex_stall) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, resp_result, exp_res);
    check({tag, "_busy_stall"}, stall_ok, 1);
    check({tag, "_done_stall"}, ex_stall, 1);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    #1;
    check("consume_valid", resp_valid, 0);
  endtask

  initial begin
    bit seen;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_opa    = 32'h0;
    req_opb    = 32'h0;
    req_op     = 2'b00;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_ex_stall", ex_stall, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("mulhu_max", 32, 32'hFFFF_FFFE);
    consume();
    issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD);
    wait_resp("mul_neg3", 32, 32'hFFFF_FFEB);
    consume();
    issue(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_resp("mulh_minsq", 32, 32'h4000_0000);
    consume();
    issue(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_resp("mulh_maxsq", 32, 32'h3FFF_FFFF);
    consume();
    issue(2'b10, 32'h8000_0000, 32'h8000_0000);
    wait_resp("mulhsu_min", 32, 32'hC000_0000);
    consume();
    issue(2'b01, 32'h0000_0000, 32'h8000_0000);
    wait_resp("mulh_zero", 32, 32'h0000_0000);
    consume();
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_resp("mulh_neg1", 32, 32'hFFFF_FFFF);
    consume();

    // Back-to-back: new request accepted on the same edge the result is consumed.
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("mulhsu_neg", 32, 32'hFFFF_FFFF);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 2'b00;
    req_opa    = 32'h0000_3039;
    req_opb    = 32'h0000_03E8;
    #1;
    check("b2b_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    wait_resp("b2b", 32, 32'h00BC_5EA8);
    consume();

    // Result held while resp_ready stays low; competing request must not be taken.
    issue(2'b00, 32'h0000_3039, 32'h0000_03E8);
    wait_resp("hold", 32, 32'h00BC_5EA8);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_op    = 2'b11;
      req_opa   = 32'h0000_0005;
      req_opb   = 32'h0000_0006;
      #1;
      check("hold_req_ready", req_ready, 0);
      check("hold_ex_stall", ex_stall, 1);
      @(posedge clk);
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_result", resp_result, 32'h00BC_5EA8);
    end
    req_valid = 1'b0;
    consume();
    check("hold_after_ready", req_ready, 1);
    check("hold_after_stall", ex_stall, 0);

    // Flush ten cycles into BUSY, with a request presented in the flush cycle.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    #1;
    check("flush_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_resp_valid", resp_valid, 0);
    check("flush_idle_ready", req_ready, 1);
    check("flush_idle_stall", ex_stall, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", seen, 0);

    // Asynchronous reset mid-BUSY clears outputs immediately and drops the result.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_result", resp_result, 0);
    check("midrst_ex_stall", ex_stall, 0);
    check("midrst_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", seen, 0);

    issue(2'b11, 32'h0001_0000, 32'h0001_0000);
    wait_resp("post_rst", 32, 32'h0000_0001);
    consume();

`ifdef EX_MUL_SEQ_REUSE_EN
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_resp("reuse_mulh", 32, 32'hF8CC_93D6);
    consume();
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_resp("reuse_hit", 0, 32'h242D_2080);
    consume();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_resp("reuse_flushed", 32, 32'h242D_2080);
    consume();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
